// File: rtl/buzzer_driver.sv
// ---------------------------------------------------------------------------
// buzzer_driver
//
// Square-wave tone generator for the board buzzer. It takes the registered
// note code and LED pattern from the mode controller and drives the buzzer
// pin. Pitch changes only happen on full-period boundaries, so the buzzer
// never gets a truncated pulse. It also reports which note is sounding.
//
// Parameters:
//   CLK_HZ      system clock frequency. Half-period counts are derived from
//               the 100 MHz table by rescaling with rounding.
//   GAP_CYCLES  length of the articulation gap (used only with
//               BUZZER_ARTIC_EN).
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous reset, active low
//   note_in   in   4  0 rest, 1-7 C4..B4, 8-14 C5..B5, 15 rest
//   led_in    in   7  LED pattern accompanying note_in
//   buzzer    out  1  square-wave drive
//   playing   out  1  high while a note is sounding
//   note_cur  out  4  code currently sounding, 0 when silent
//   note_ack  out  1  one-cycle pulse when a new note starts sounding
//   led_out   out  7  led_in captured when a note is accepted
//
// Optional feature (macro BUZZER_ARTIC_EN):
//   When it is defined, a change to a different valid note goes through a
//   silent GAP of GAP_CYCLES cycles before the new note starts. When it is
//   undefined, note changes are seamless at the period boundary.
// ---------------------------------------------------------------------------
module buzzer_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note_in,
    input  logic [6:0] led_in,
    output logic       buzzer,
    output logic       playing,
    output logic [3:0] note_cur,
    output logic       note_ack,
    output logic [6:0] led_out
);

    // Rescale a 100 MHz half-period count to CLK_HZ, rounding to nearest.
    function automatic logic [17:0] scale_half(input longint base);
        longint scaled;
        scaled = (base * longint'(CLK_HZ) + 64'sd50_000_000) / 64'sd100_000_000;
        return 18'(scaled);
    endfunction

    localparam logic [17:0] HALF_C4 = scale_half(191113);
    localparam logic [17:0] HALF_D4 = scale_half(170262);
    localparam logic [17:0] HALF_E4 = scale_half(151686);
    localparam logic [17:0] HALF_F4 = scale_half(143173);
    localparam logic [17:0] HALF_G4 = scale_half(127551);
    localparam logic [17:0] HALF_A4 = scale_half(113636);
    localparam logic [17:0] HALF_B4 = scale_half(101239);
    localparam logic [17:0] HALF_C5 = scale_half(95557);
    localparam logic [17:0] HALF_D5 = scale_half(85131);
    localparam logic [17:0] HALF_E5 = scale_half(75843);
    localparam logic [17:0] HALF_F5 = scale_half(71587);
    localparam logic [17:0] HALF_G5 = scale_half(63776);
    localparam logic [17:0] HALF_A5 = scale_half(56818);
    localparam logic [17:0] HALF_B5 = scale_half(50620);

    function automatic logic [17:0] half_of(input logic [3:0] code);
        case (code)
            4'd1:    return HALF_C4;
            4'd2:    return HALF_D4;
            4'd3:    return HALF_E4;
            4'd4:    return HALF_F4;
            4'd5:    return HALF_G4;
            4'd6:    return HALF_A4;
            4'd7:    return HALF_B4;
            4'd8:    return HALF_C5;
            4'd9:    return HALF_D5;
            4'd10:   return HALF_E5;
            4'd11:   return HALF_F5;
            4'd12:   return HALF_G5;
            4'd13:   return HALF_A5;
            4'd14:   return HALF_B5;
            default: return 18'd0;
        endcase
    endfunction

    // Codes 0 and 15 are both rests.
    function automatic logic valid_code(input logic [3:0] code);
        return (code != 4'd0) && (code != 4'd15);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t      state;
    logic [3:0]  note_q;
    logic [6:0]  led_q;
    logic [17:0] half;
    logic [17:0] cnt;

`ifdef BUZZER_ARTIC_EN
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    logic [31:0] gap_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_q <= 4'd0;
            led_q  <= 7'd0;
        end else begin
            note_q <= note_in;
            led_q  <= led_in;
        end
    end

    // Main tone FSM. The buzzer level flips after `half` cycles; a full
    // period ends when the low half expires, and only then is note_q
    // consulted, so a note is never cut short or changed mid-pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            half     <= 18'd0;
            cnt      <= 18'd0;
            buzzer   <= 1'b0;
            playing  <= 1'b0;
            note_cur <= 4'd0;
            note_ack <= 1'b0;
            led_out  <= 7'd0;
`ifdef BUZZER_ARTIC_EN
            gap_cnt  <= 32'd0;
`endif
        end else begin
            note_ack <= 1'b0;
            case (state)
                IDLE: begin
                    buzzer   <= 1'b0;
                    playing  <= 1'b0;
                    note_cur <= 4'd0;
                    cnt      <= 18'd0;
                    if (valid_code(note_q)) begin
                        state    <= PLAY;
                        half     <= half_of(note_q);
                        note_cur <= note_q;
                        led_out  <= led_q;
                        note_ack <= 1'b1;
                        buzzer   <= 1'b1;
                        playing  <= 1'b1;
                    end
                end

                PLAY: begin
                    if (cnt == half - 18'd1) begin
                        cnt <= 18'd0;
                        if (buzzer) begin
                            buzzer <= 1'b0;
                        end else if (note_q == note_cur) begin
                            buzzer <= 1'b1;
                        end else if (!valid_code(note_q)) begin
                            state    <= IDLE;
                            playing  <= 1'b0;
                            note_cur <= 4'd0;
                        end else begin
`ifdef BUZZER_ARTIC_EN
                            state    <= GAP;
                            playing  <= 1'b0;
                            note_cur <= 4'd0;
                            gap_cnt  <= 32'd0;
`else
                            half     <= half_of(note_q);
                            note_cur <= note_q;
                            led_out  <= led_q;
                            note_ack <= 1'b1;
                            buzzer   <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end

`ifdef BUZZER_ARTIC_EN
                // Silent separation; the new note is re-sampled at the end
                // so a rest arriving during the gap is honoured.
                GAP: begin
                    buzzer   <= 1'b0;
                    playing  <= 1'b0;
                    note_cur <= 4'd0;
                    cnt      <= 18'd0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 32'd0;
                        if (valid_code(note_q)) begin
                            state    <= PLAY;
                            half     <= half_of(note_q);
                            note_cur <= note_q;
                            led_out  <= led_q;
                            note_ack <= 1'b1;
                            buzzer   <= 1'b1;
                            playing  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    buzzer   <= 1'b0;
                    playing  <= 1'b0;
                    note_cur <= 4'd0;
                    cnt      <= 18'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/buzzer_driver.md
# buzzer_driver

Tone generator at the far end of the note bus: consumes the 4-bit note code and the 7-bit LED pattern driven by the mode controller and produces the square-wave drive for the board buzzer. It sits between the controller's registered `note_out`/`led_out` and the top-level pins. It switches pitch only on full-period boundaries, so the buzzer never sees a truncated pulse. It reports which note is actually sounding.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; divider table is round(CLK_HZ / (2·f_note)).
- `GAP_CYCLES`, 2_000_000: length of the articulation gap (only with `BUZZER_ARTIC_EN`).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `note_in`  in  4  note code: 0 rest; 1–7 C4,D4,E4,F4,G4,A4,B4; 8–14 C5..B5; 15 treated as rest.
- `led_in`  in  7  LED pattern accompanying `note_in`.
- `buzzer`  out  1  square-wave drive.
- `playing`  out  1  high while a valid note is sounding (PLAY state).
- `note_cur`  out  4  code currently sounding; 0 when silent.
- `note_ack`  out  1  one-cycle pulse when a new note starts sounding.
- `led_out`  out  7  `led_in` registered with the same acceptance as the note.

## Operation
- `note_in`/`led_in` are registered every cycle into `note_q`/`led_q`. All decisions use `note_q`.
- Half-period counts at 100 MHz, 18-bit:
  - C4..B4: 191113, 170262, 151686, 143173, 127551, 113636, 101239.
  - C5..B5: 95557, 85131, 75843, 71587, 63776, 56818, 50620.
- Counter `cnt` (18 bit) runs 0..half−1. At `cnt == half−1`, `buzzer` toggles and `cnt` returns to 0. Each level lasts exactly `half` cycles.
- States:
  - IDLE: `buzzer`=0, `playing`=0, `note_cur`=0, `cnt`=0. If `note_q` is 1–14: latch `half`, set `note_cur`=`note_q`, set `led_out`=`led_q`, pulse `note_ack`, go to PLAY with `buzzer`=1.
  - PLAY: at the full-period boundary (`cnt == half−1` while `buzzer`=0), sample `note_q`:
    - same code → continue.
    - rest/15 → IDLE, `buzzer` stays 0.
    - different valid code → reload `half`, update `note_cur`/`led_out`, pulse `note_ack`, `buzzer`→1, `cnt`=0.
    - Changes between boundaries are ignored until the boundary.
  - GAP (only with macro): `buzzer`=0, `playing`=0, `note_cur`=0. Counts `GAP_CYCLES`, then re-samples `note_q`:
    - valid → start it as from IDLE.
    - rest → IDLE.
- `led_out` holds its last accepted value in IDLE. It updates only when a note is accepted.

## Timing
- Reset values: `buzzer`=0, `playing`=0, `note_cur`=0, `note_ack`=0, `led_out`=0, state IDLE, `cnt`=0.
- Reset is asserted asynchronously. All outputs clear immediately, including mid-period and mid-GAP.
- IDLE latency: `note_in` sampled at edge k → `note_q` at k → `buzzer`=1, `note_ack`=1 after edge k+1 (2 cycles).
- PLAY latency: 1 cycle of input register plus up to one full period of the current note.
- `note_ack` is high exactly one cycle per accepted note, coincident with the first high cycle of `buzzer`.
- Simultaneous boundary and input change: the value registered in `note_q` on that cycle wins.

## Configuration
- `BUZZER_ARTIC_EN` defined:
  - A PLAY boundary seeing a different valid code goes to GAP for `GAP_CYCLES` before the new note. This gives audible separation of repeated melodies.
  - A boundary seeing rest goes to IDLE directly.
- Undefined: no GAP state. Note changes are seamless at the period boundary.

## Test plan
- Reset, `note_in`=6: `note_ack` and `buzzer`=1 two cycles after the input edge. `buzzer` high 113636, low 113636, repeating. `note_cur`=6, `playing`=1.
- While playing 6, set `note_in`=1 at `cnt`=1000 of the high half: first period finishes at 113636/113636. Then `buzzer` switches to 191113/191113 with one `note_ack`.
- Playing 14, set `note_in`=0: `buzzer` ends low after the full 50620/50620 period. `playing`=0, `note_cur`=0, `led_out` unchanged.
- `note_in`=15 from IDLE: stays silent, no `note_ack`. Glitch `note_in` 3→5→3 within one half-period: pitch stays 151686, no `note_ack`.
- Assert `reset` low mid-high-half of note 8: `buzzer`, `playing`, `note_cur` are 0 within the same cycle. Release: restarts cleanly from IDLE.
- With `BUZZER_ARTIC_EN`, `GAP_CYCLES`=100: 1→2 change gives `buzzer`=0 for exactly 100 cycles after the boundary. Then `note_ack` and 170262-cycle halves.
